// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, issues req/ack fetches, holds each
// instruction until the consumer accepts it, then advances sequentially or by branch.
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [63:0] inst_pc,
   input  logic        inst_ready,
   input  logic        BrTaken,
   input  logic        UncondBr,
   output logic        fetch_err,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_ERROR = 2'd2
   } state_e;

   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;

   logic [63:0] imm26_off, imm19_off, br_off, next_pc;

   // Word offsets are sign-extended and scaled by 4 in one concatenation.
   assign imm26_off = {{36{inst_q[25]}}, inst_q[25:0], 2'b00};
   assign imm19_off = {{43{inst_q[23]}}, inst_q[23:5], 2'b00};
   assign br_off    = UncondBr ? imm26_off : imm19_off;
   assign next_pc   = inst_pc_q + (BrTaken ? br_off : 64'd4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wait_cnt_d = wait_cnt_q;
      retired_d  = retired_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               state_d   = S_HOLD;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
               if (wait_cnt_q == TIMEOUT_M1) state_d = S_ERROR;
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               pc_d       = next_pc;
               retired_d  = retired_q + 32'd1;
               wait_cnt_d = '0;
               state_d    = S_FETCH;
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         wait_cnt_q <= '0;
         retired_q  <= '0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wait_cnt_q <= wait_cnt_d;
         retired_q  <= retired_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
      end
   end

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == S_HOLD);
   assign inst_out   = inst_q;
   assign inst_pc    = inst_pc_q;
   assign fetch_err  = (state_q == S_ERROR);
   assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of fetch/accept transactions plus
// hand-written timeout and reset-in-HOLD sequences.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic        inst_ready;
   logic        BrTaken;
   logic        UncondBr;
   logic        fetch_err;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;

   fetch_sequencer #(.RESET_PC(64'd0), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_out   (inst_out),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .BrTaken    (BrTaken),
      .UncondBr   (UncondBr),
      .fetch_err  (fetch_err),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          delay;
      int          hold;
      logic [31:0] rdata;
      logic        br;
      logic        unc;
      logic [63:0] pc;
      logic [63:0] next;
   } vec_t;

   vec_t vec [14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      inst_ready = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;

      vec[0]  = '{0, 0, 32'h1234_5678, 1'b0, 1'b0, 64'h0,                  64'h4};
      vec[1]  = '{3, 5, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h4,                  64'h8};
      vec[2]  = '{1, 0, 32'h1400_0002, 1'b1, 1'b1, 64'h8,                  64'h10};
      vec[3]  = '{2, 1, 32'h54FF_FFC0, 1'b1, 1'b0, 64'h10,                 64'h08};
      vec[4]  = '{0, 0, 32'h1400_0006, 1'b1, 1'b1, 64'h8,                  64'h20};
      vec[5]  = '{0, 0, 32'h1400_0003, 1'b1, 1'b1, 64'h20,                 64'h2C};
      vec[6]  = '{4, 0, 32'h17FF_FFFD, 1'b1, 1'b1, 64'h2C,                 64'h20};
      vec[7]  = '{0, 2, 32'h1400_0003, 1'b0, 1'b1, 64'h20,                 64'h24};
      vec[8]  = '{15, 0, 32'h5480_0000, 1'b1, 1'b0, 64'h24,                64'hFFFF_FFFF_FFF0_0024};
      vec[9]  = '{0, 0, 32'h1600_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFF0_0024, 64'hFFFF_FFFF_F7F0_0024};
      vec[10] = '{1, 0, 32'h15FF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_F7F0_0024, 64'hFFFF_FFFF_FFF0_0020};
      vec[11] = '{0, 0, 32'h547F_FEE0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFF0_0020, 64'hFFFF_FFFF_FFFF_FFFC};
      vec[12] = '{0, 0, 32'h1400_0003, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
      vec[13] = '{0, 0, 32'h0000_0000, 1'b1, 1'b0, 64'h0,                  64'h0};

      do_reset();
      chk("rst_req",     {63'd0, imem_req},   64'd1);
      chk("rst_addr",    imem_addr,           64'h0);
      chk("rst_valid",   {63'd0, inst_valid}, 64'd0);
      chk("rst_err",     {63'd0, fetch_err},  64'd0);
      chk("rst_retired", {32'd0, retired},    64'd0);
      chk("rst_inst",    {32'd0, inst_out},   64'd0);
      chk("rst_ipc",     inst_pc,             64'd0);

      for (int i = 0; i < 14; i++) begin
         // un-acked request cycles: junk data and stray ready must be ignored
         for (int d = 0; d < vec[i].delay; d++) begin
            chk($sformatf("v%0d_wait_req", i),  {63'd0, imem_req}, 64'd1);
            chk($sformatf("v%0d_wait_addr", i), imem_addr, vec[i].pc);
            imem_ack = 1'b0; imem_rdata = $urandom; inst_ready = 1'b1;
            @(negedge clk);
         end
         chk($sformatf("v%0d_req", i),  {63'd0, imem_req}, 64'd1);
         chk($sformatf("v%0d_addr", i), imem_addr, vec[i].pc);
         imem_ack = 1'b1; imem_rdata = vec[i].rdata; inst_ready = 1'b0;
         @(negedge clk);
         imem_ack = 1'b0; imem_rdata = '0;
         chk($sformatf("v%0d_valid", i), {63'd0, inst_valid}, 64'd1);
         chk($sformatf("v%0d_noreq", i), {63'd0, imem_req},   64'd0);
         chk($sformatf("v%0d_inst", i),  {32'd0, inst_out},   {32'd0, vec[i].rdata});
         chk($sformatf("v%0d_ipc", i),   inst_pc,             vec[i].pc);
         for (int h = 0; h < vec[i].hold; h++) begin
            imem_ack = 1'b1; imem_rdata = ~vec[i].rdata; BrTaken = ~vec[i].br;
            @(negedge clk);
            chk($sformatf("v%0d_hold_inst", i),  {32'd0, inst_out},   {32'd0, vec[i].rdata});
            chk($sformatf("v%0d_hold_valid", i), {63'd0, inst_valid}, 64'd1);
            chk($sformatf("v%0d_hold_req", i),   {63'd0, imem_req},   64'd0);
         end
         imem_ack = 1'b0;
         inst_ready = 1'b1; BrTaken = vec[i].br; UncondBr = vec[i].unc;
         @(negedge clk);
         inst_ready = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
         chk($sformatf("v%0d_next_req", i),  {63'd0, imem_req}, 64'd1);
         chk($sformatf("v%0d_next_addr", i), imem_addr, vec[i].next);
         chk($sformatf("v%0d_retired", i),   {32'd0, retired}, 64'(i + 1));
         chk($sformatf("v%0d_err", i),       {63'd0, fetch_err}, 64'd0);
      end

      // Timeout: 16 un-acked request cycles enter ERROR, sticky until reset
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         chk($sformatf("to_c%0d_req", c), {63'd0, imem_req},  64'd1);
         chk($sformatf("to_c%0d_err", c), {63'd0, fetch_err}, 64'd0);
         @(negedge clk);
      end
      chk("to_c16_req", {63'd0, imem_req}, 64'd1);
      @(negedge clk);
      chk("to_err",   {63'd0, fetch_err},  64'd1);
      chk("to_noreq", {63'd0, imem_req},   64'd0);
      chk("to_noval", {63'd0, inst_valid}, 64'd0);
      imem_ack = 1'b1; inst_ready = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0; inst_ready = 1'b0;
      chk("to_sticky_err", {63'd0, fetch_err}, 64'd1);
      chk("to_sticky_req", {63'd0, imem_req},  64'd0);
      do_reset();
      chk("to_rst_err",  {63'd0, fetch_err}, 64'd0);
      chk("to_rst_req",  {63'd0, imem_req},  64'd1);
      chk("to_rst_addr", imem_addr,          64'h0);

      // Advance a couple of instructions, then reset in HOLD alongside acceptance
      for (int k = 0; k < 2; k++) begin
         imem_ack = 1'b1; imem_rdata = 32'h1400_0001;
         @(negedge clk);
         imem_ack = 1'b0; inst_ready = 1'b1;
         @(negedge clk);
         inst_ready = 1'b0;
      end
      chk("pre_rst_retired", {32'd0, retired}, 64'd2);
      chk("pre_rst_addr",    imem_addr,        64'h8);
      imem_ack = 1'b1; imem_rdata = 32'h1400_0005;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("hr_valid", {63'd0, inst_valid}, 64'd1);
      rst = 1'b1; inst_ready = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1;
      @(negedge clk);
      rst = 1'b0; inst_ready = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
      chk("hr_retired", {32'd0, retired},    64'd0);
      chk("hr_valid0",  {63'd0, inst_valid}, 64'd0);
      chk("hr_req",     {63'd0, imem_req},   64'd1);
      chk("hr_addr",    imem_addr,           64'h0);
      chk("hr_inst",    {32'd0, inst_out},   64'd0);
      imem_ack = 1'b1; imem_rdata = 32'h1400_0005;
      @(negedge clk);
      imem_ack = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      chk("hr_after_retired", {32'd0, retired}, 64'd1);
      chk("hr_after_addr",    imem_addr,        64'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
